// File: rtl/writeback_arbiter_l5.sv
// ---------------------------------------------------------------------------
// writeback_arbiter_l5
//
// Purpose:
//   Merges p_num_units execute-unit result streams (X) into a single
//   registered writeback stream (W) using round-robin arbitration, one
//   result per cycle. Also keeps a saturating completion counter per unit.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active low
//   x_val/x_rdy                      per-unit handshake
//   x_pc, x_seq_num, x_waddr, x_wdata, x_wen, x_preg, x_ppreg
//                                    per-unit result fields, unit i in slice i
//   w_val/w_rdy                      registered output handshake
//   w_pc .. w_ppreg                  registered result fields
//   w_unit     source unit of the current W result
//   done_cnt   per-unit count of results accepted by writeback (saturating)
// ---------------------------------------------------------------------------
module writeback_arbiter_l5 #(
    parameter int p_num_units      = 4,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6,
    parameter int p_cnt_bits       = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [p_num_units-1:0]                  x_val,
    output logic [p_num_units-1:0]                  x_rdy,
    input  logic [p_num_units*32-1:0]               x_pc,
    input  logic [p_num_units*p_seq_num_bits-1:0]   x_seq_num,
    input  logic [p_num_units*5-1:0]                x_waddr,
    input  logic [p_num_units*32-1:0]               x_wdata,
    input  logic [p_num_units-1:0]                  x_wen,
    input  logic [p_num_units*p_phys_addr_bits-1:0] x_preg,
    input  logic [p_num_units*p_phys_addr_bits-1:0] x_ppreg,
    output logic                                    w_val,
    input  logic                                    w_rdy,
    output logic [31:0]                             w_pc,
    output logic [p_seq_num_bits-1:0]               w_seq_num,
    output logic [4:0]                              w_waddr,
    output logic [31:0]                             w_wdata,
    output logic                                    w_wen,
    output logic [p_phys_addr_bits-1:0]             w_preg,
    output logic [p_phys_addr_bits-1:0]             w_ppreg,
    output logic [$clog2(p_num_units)-1:0]          w_unit,
    output logic [p_num_units*p_cnt_bits-1:0]       done_cnt
);

    localparam int lp_n  = p_num_units;
    localparam int lp_ub = $clog2(p_num_units);
    localparam int lp_sq = p_seq_num_bits;
    localparam int lp_pa = p_phys_addr_bits;

    // Unpacked views of the per-unit field buses
    logic [31:0]      w_pc_arr    [lp_n];
    logic [lp_sq-1:0] w_seq_arr   [lp_n];
    logic [4:0]       w_waddr_arr [lp_n];
    logic [31:0]      w_wdata_arr [lp_n];
    logic [lp_pa-1:0] w_preg_arr  [lp_n];
    logic [lp_pa-1:0] w_ppreg_arr [lp_n];

    genvar gi;
    generate
        for (gi = 0; gi < lp_n; gi++) begin : g_unpack
            assign w_pc_arr[gi]    = x_pc[32*gi +: 32];
            assign w_seq_arr[gi]   = x_seq_num[lp_sq*gi +: lp_sq];
            assign w_waddr_arr[gi] = x_waddr[5*gi +: 5];
            assign w_wdata_arr[gi] = x_wdata[32*gi +: 32];
            assign w_preg_arr[gi]  = x_preg[lp_pa*gi +: lp_pa];
            assign w_ppreg_arr[gi] = x_ppreg[lp_pa*gi +: lp_pa];
        end
    endgenerate

    // Output register state
    logic             r_w_val;
    logic [31:0]      r_pc;
    logic [lp_sq-1:0] r_seq;
    logic [4:0]       r_waddr;
    logic [31:0]      r_wdata;
    logic             r_wen;
    logic [lp_pa-1:0] r_preg;
    logic [lp_pa-1:0] r_ppreg;
    logic [lp_ub-1:0] r_unit;
    logic [lp_ub-1:0] r_ptr;

    logic             w_can_load;
    logic             w_grant_any;
    logic [lp_ub-1:0] w_grant_idx;
    logic [lp_ub-1:0] w_ptr_next;
    logic             w_w_xfer;

    assign w_can_load = !r_w_val || w_rdy;
    assign w_w_xfer   = r_w_val && w_rdy;

    // Round-robin search starting at r_ptr; first valid unit wins.
    // Gated by rst so no unit is told "ready" while reset is asserted.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (rst && w_can_load) begin
            for (int k = 0; k < lp_n; k++) begin
                v_idx = int'(r_ptr) + k;
                if (v_idx >= lp_n) begin
                    v_idx = v_idx - lp_n;
                end
                if (!w_grant_any && x_val[v_idx]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = lp_ub'(v_idx);
                end
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == lp_ub'(lp_n - 1)) ? '0 : w_grant_idx + 1'b1;

    generate
        for (gi = 0; gi < lp_n; gi++) begin : g_rdy
            assign x_rdy[gi] = w_grant_any && (w_grant_idx == lp_ub'(gi));
        end
    endgenerate

    // A grant implies x_val of the granted unit, so a grant is a transfer.
    // Load on grant covers the back-to-back case; otherwise a W transfer
    // empties the register and the fields simply hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_val <= 1'b0;
            r_pc    <= '0;
            r_seq   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_preg  <= '0;
            r_ppreg <= '0;
            r_unit  <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_grant_any) begin
                r_w_val <= 1'b1;
                r_pc    <= w_pc_arr[w_grant_idx];
                r_seq   <= w_seq_arr[w_grant_idx];
                r_waddr <= w_waddr_arr[w_grant_idx];
                r_wdata <= w_wdata_arr[w_grant_idx];
                r_wen   <= x_wen[w_grant_idx];
                r_preg  <= w_preg_arr[w_grant_idx];
                r_ppreg <= w_ppreg_arr[w_grant_idx];
                r_unit  <= w_grant_idx;
                r_ptr   <= w_ptr_next;
            end else if (w_rdy) begin
                r_w_val <= 1'b0;
            end
        end
    end

    // Per-unit saturating completion counters, credited on W acceptance
    generate
        for (gi = 0; gi < lp_n; gi++) begin : g_cnt
            logic [p_cnt_bits-1:0] r_cnt;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (w_w_xfer && (r_unit == lp_ub'(gi)) && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign done_cnt[p_cnt_bits*gi +: p_cnt_bits] = r_cnt;
        end
    endgenerate

    assign w_val     = r_w_val;
    assign w_pc      = r_pc;
    assign w_seq_num = r_seq;
    assign w_waddr   = r_waddr;
    assign w_wdata   = r_wdata;
    assign w_wen     = r_wen;
    assign w_preg    = r_preg;
    assign w_ppreg   = r_ppreg;
    assign w_unit    = r_unit;

endmodule

// File: tb/tb_writeback_arbiter_l5.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter_l5
//
// Directed bench for writeback_arbiter_l5. The stimulus process pushes the
// expected W result (hand-chosen grant order) into a scoreboard queue; a
// monitor pops and compares whenever the DUT completes a W handshake.
// A second instance with 2-bit counters exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter_l5;

    localparam int N   = 4;
    localparam int SEQ = 5;
    localparam int PA  = 6;
    localparam int CNT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]      x_val, x_rdy, x_wen;
    logic [N*32-1:0]   x_pc, x_wdata;
    logic [N*SEQ-1:0]  x_seq_num;
    logic [N*5-1:0]    x_waddr;
    logic [N*PA-1:0]   x_preg, x_ppreg;
    logic              w_val, w_rdy, w_wen;
    logic [31:0]       w_pc, w_wdata;
    logic [SEQ-1:0]    w_seq_num;
    logic [4:0]        w_waddr;
    logic [PA-1:0]     w_preg, w_ppreg;
    logic [1:0]        w_unit;
    logic [N*CNT-1:0]  done_cnt;

    // saturation instance
    logic [N-1:0]      s_x_val, s_x_rdy;
    logic              s_w_val, s_w_wen;
    logic [31:0]       s_w_pc, s_w_wdata;
    logic [SEQ-1:0]    s_w_seq_num;
    logic [4:0]        s_w_waddr;
    logic [PA-1:0]     s_w_preg, s_w_ppreg;
    logic [1:0]        s_w_unit;
    logic [N*2-1:0]    s_done_cnt;

    writeback_arbiter_l5 #(.p_num_units(N), .p_seq_num_bits(SEQ),
                           .p_phys_addr_bits(PA), .p_cnt_bits(CNT)) dut (
        .clk(clk), .rst(rst),
        .x_val(x_val), .x_rdy(x_rdy), .x_pc(x_pc), .x_seq_num(x_seq_num),
        .x_waddr(x_waddr), .x_wdata(x_wdata), .x_wen(x_wen),
        .x_preg(x_preg), .x_ppreg(x_ppreg),
        .w_val(w_val), .w_rdy(w_rdy), .w_pc(w_pc), .w_seq_num(w_seq_num),
        .w_waddr(w_waddr), .w_wdata(w_wdata), .w_wen(w_wen),
        .w_preg(w_preg), .w_ppreg(w_ppreg), .w_unit(w_unit),
        .done_cnt(done_cnt)
    );

    writeback_arbiter_l5 #(.p_num_units(N), .p_seq_num_bits(SEQ),
                           .p_phys_addr_bits(PA), .p_cnt_bits(2)) dut_s (
        .clk(clk), .rst(rst),
        .x_val(s_x_val), .x_rdy(s_x_rdy), .x_pc(x_pc), .x_seq_num(x_seq_num),
        .x_waddr(x_waddr), .x_wdata(x_wdata), .x_wen(x_wen),
        .x_preg(x_preg), .x_ppreg(x_ppreg),
        .w_val(s_w_val), .w_rdy(w_rdy), .w_pc(s_w_pc), .w_seq_num(s_w_seq_num),
        .w_waddr(s_w_waddr), .w_wdata(s_w_wdata), .w_wen(s_w_wen),
        .w_preg(s_w_preg), .w_ppreg(s_w_ppreg), .w_unit(s_w_unit),
        .done_cnt(s_done_cnt)
    );

    typedef struct {
        logic [1:0]     unit;
        logic [31:0]    pc;
        logic [SEQ-1:0] seq;
        logic [4:0]     waddr;
        logic [31:0]    wdata;
        logic           wen;
        logic [PA-1:0]  preg;
        logic [PA-1:0]  ppreg;
    } exp_t;

    exp_t sb[$];

    // bench-owned per-unit field table
    logic [31:0]    t_pc    [N];
    logic [SEQ-1:0] t_seq   [N];
    logic [4:0]     t_waddr [N];
    logic [31:0]    t_wdata [N];
    logic           t_wen   [N];
    logic [PA-1:0]  t_preg  [N];
    logic [PA-1:0]  t_ppreg [N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            x_pc[32*i +: 32]       = t_pc[i];
            x_seq_num[SEQ*i +: SEQ] = t_seq[i];
            x_waddr[5*i +: 5]      = t_waddr[i];
            x_wdata[32*i +: 32]    = t_wdata[i];
            x_wen[i]               = t_wen[i];
            x_preg[PA*i +: PA]     = t_preg[i];
            x_ppreg[PA*i +: PA]    = t_ppreg[i];
        end
    endtask

    task automatic push(input int u);
        exp_t e;
        e.unit  = 2'(u);
        e.pc    = t_pc[u];
        e.seq   = t_seq[u];
        e.waddr = t_waddr[u];
        e.wdata = t_wdata[u];
        e.wen   = t_wen[u];
        e.preg  = t_preg[u];
        e.ppreg = t_ppreg[u];
        sb.push_back(e);
    endtask

    // Monitor: a W handshake is seen on the falling edge before it completes
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (w_val && w_rdy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected got unit %0d seq %0h expected none", w_unit, w_seq_num);
                end else begin
                    e = sb.pop_front();
                    chk("mon_unit",  64'(w_unit),    64'(e.unit));
                    chk("mon_pc",    64'(w_pc),      64'(e.pc));
                    chk("mon_seq",   64'(w_seq_num), 64'(e.seq));
                    chk("mon_waddr", 64'(w_waddr),   64'(e.waddr));
                    chk("mon_wdata", 64'(w_wdata),   64'(e.wdata));
                    chk("mon_wen",   64'(w_wen),     64'(e.wen));
                    chk("mon_preg",  64'(w_preg),    64'(e.preg));
                    chk("mon_ppreg", 64'(w_ppreg),   64'(e.ppreg));
                    $display("W xfer unit %0d seq %0h wdata %0h", w_unit, w_seq_num, w_wdata);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            t_pc[i]    = 32'h100 + 32'(16 * i);
            t_seq[i]   = 5'(i + 8);
            t_waddr[i] = 5'(i + 10);
            t_wdata[i] = 32'hA000_0000 + 32'(i);
            t_wen[i]   = 1'(i % 2);
            t_preg[i]  = 6'(i + 20);
            t_ppreg[i] = 6'(i + 40);
        end
        x_val   = '0;
        s_x_val = '0;
        w_rdy   = 1'b1;
        drive_fields();
        #1 rst = 1'b0;
        step();
        step();
        chk("rst_w_val",    64'(w_val),      64'd0);
        chk("rst_x_rdy",    64'(x_rdy),      64'd0);
        chk("rst_done_cnt", 64'(done_cnt),   64'd0);
        chk("rst_s_cnt",    64'(s_done_cnt), 64'd0);

        // 1: idle after release
        rst = 1'b1;
        step(); step(); step();
        chk("idle_w_val",    64'(w_val),    64'd0);
        chk("idle_x_rdy",    64'(x_rdy),    64'd0);
        chk("idle_done_cnt", 64'(done_cnt), 64'd0);

        // 2: single unit 2 result
        t_seq[2]   = 5'd5;
        t_waddr[2] = 5'd3;
        t_wdata[2] = 32'h1234;
        drive_fields();
        x_val = 4'b0100;
        #1;
        chk("u2_x_rdy", 64'(x_rdy), 64'b0100);
        push(2);
        step();
        x_val = 4'b0000;
        #1;
        chk("u2_w_val",  64'(w_val),     64'd1);
        chk("u2_w_seq",  64'(w_seq_num), 64'd5);
        chk("u2_w_unit", 64'(w_unit),    64'd2);
        step();
        chk("u2_drained", 64'(w_val), 64'd0);

        // ptr must now be 3: units 0 and 3 valid -> unit 3 wins
        x_val = 4'b1001;
        #1;
        chk("ptr3_x_rdy", 64'(x_rdy), 64'b1000);
        push(3);
        step();

        // 3: all valid, back-to-back order 0,1,2,3,0
        x_val = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_x_rdy", 64'(x_rdy), 64'(4'b0001 << (k % 4)));
            push(k % 4);
            step();
        end

        // 4: stall with unit 0 result held
        w_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_x_rdy",  64'(x_rdy),     64'd0);
            chk("stall_w_val",  64'(w_val),     64'd1);
            chk("stall_w_unit", 64'(w_unit),    64'd0);
            chk("stall_w_seq",  64'(w_seq_num), 64'(t_seq[0]));
            step();
        end
        w_rdy = 1'b1;
        #1;
        chk("unstall_x_rdy", 64'(x_rdy), 64'b0010);
        push(1);
        step();
        x_val = 4'b0000;
        step();
        #1;
        chk("t4_drained",  64'(w_val),    64'd0);
        chk("t4_done_cnt", 64'(done_cnt), {16'd2, 16'd2, 16'd2, 16'd2});

        // 6: reset while a result is in flight
        w_rdy = 1'b0;
        x_val = 4'b0100;
        #1;
        chk("t6_x_rdy", 64'(x_rdy), 64'b0100);
        step();
        #1;
        chk("t6_loaded", 64'(w_val), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_async_w_val", 64'(w_val),    64'd0);
        chk("t6_async_cnt",   64'(done_cnt), 64'd0);
        chk("t6_async_x_rdy", 64'(x_rdy),    64'd0);
        x_val = 4'b0000;
        w_rdy = 1'b1;
        step();
        rst = 1'b1;

        // 5: after reset ptr=0; unit 1 three times, unit 3 once
        x_val = 4'b1010;
        #1;
        chk("resume_x_rdy", 64'(x_rdy), 64'b0010);
        push(1);
        step();
        #1;
        chk("t5_x_rdy_a", 64'(x_rdy), 64'b1000);
        push(3);
        step();
        #1;
        chk("t5_x_rdy_b", 64'(x_rdy), 64'b0010);
        push(1);
        step();
        x_val = 4'b0010;
        #1;
        chk("t5_x_rdy_c", 64'(x_rdy), 64'b0010);
        push(1);
        step();
        x_val = 4'b0000;
        step();
        step();
        chk("t5_done_cnt", 64'(done_cnt), {16'd1, 16'd0, 16'd3, 16'd0});

        // saturation with 2-bit counters: 5 completions on unit 0
        s_x_val = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("sat_x_rdy", 64'(s_x_rdy), 64'b0001);
            step();
            chk("sat_cnt", 64'(s_done_cnt), 64'((k - 1 > 3) ? 3 : k - 1));
        end
        s_x_val = 4'b0000;
        step();
        chk("sat_final", 64'(s_done_cnt), 64'd3);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
